// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   muldiv_op_e - MulDivOp encodings (RV32M funct3)
//   state_e     - FSM states of muldiv_unit
//   ITERATIONS  - number of shift-add / restoring-divide iterations
package muldiv_pkg;

  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 34-cycle latency.
// Multiply is shift-add and divide is restoring division, both on operand
// magnitudes; signs are applied in FIX. Both share one 2*XLEN accumulator.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset (highest priority)
//   start    - begin an operation, sampled only in IDLE
//   flush    - synchronous abort back to IDLE, Result preserved
//   MulDivOp - RV32M funct3 operation code
//   SrcA     - multiplicand / dividend
//   SrcB     - multiplier / divisor
//   busy     - high in CALC and FIX
//   done     - one-cycle pulse in DONE, Result valid
//   Result   - registered result of the last completed operation
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      MulDivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  muldiv_op_e        op_q, op_d;
  logic              neg_q, neg_d;     // negate product / quotient
  logic              negr_q, negr_d;   // negate remainder
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at start
  muldiv_op_e      op_in;
  logic            a_signed, b_signed, sa, sb, in_div;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    op_in    = muldiv_op_e'(MulDivOp);
    in_div   = MulDivOp[2];
    a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa       = a_signed & SrcA[XLEN-1];
    sb       = b_signed & SrcB[XLEN-1];
    mag_a    = sa ? -SrcA : SrcA;
    mag_b    = sb ? -SrcB : SrcB;
  end

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // acc = {partial product high, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // acc = {partial remainder, dividend bits shifting into quotient}
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
    div_next = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_val = quo;
      default:                       fix_val = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = op_in;
          acc_d   = {{XLEN{1'b0}}, in_div ? mag_a : mag_b};
          opb_d   = in_div ? mag_b : mag_a;
          // Divide by zero leaves the all-ones quotient unsigned; the
          // remainder still takes the dividend's sign so REM returns SrcA.
          neg_d   = in_div ? ((sa ^ sb) & (SrcB != '0)) : (sa ^ sb);
          negr_d  = sa;
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk, reset, start, flush;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA, SrcB, Result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .MulDivOp(MulDivOp), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and measures it. lat is the cycle index (1 = first
  // cycle after start was sampled) where done was seen, 0 on timeout.
  // Inputs are scrambled after start to show they were latched.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic done_after);
    @(negedge clk);
    MulDivOp = op; SrcA = a; SrcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; SrcA = ~a; SrcB = ~b; MulDivOp = ~op;
    lat = 0; bcnt = 0; res = 'x;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        res = Result;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  // Runs a table of vectors, checking result, latency, busy span, pulse width
  task automatic run_table(input string name, input logic [2:0] ops[4],
                           input logic [31:0] as[4], input logic [31:0] bs[4],
                           input logic [31:0] exps[4]);
    logic [31:0] res;
    int          lat, bcnt;
    logic        da;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bcnt, da);
      checks++;
      if (res !== exps[i]) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h expected %h", name, i, res, exps[i]);
      end
      checks++;
      if (lat !== 34) begin
        errors++;
        $display("FAIL %s[%0d] latency: got %0d expected 34", name, i, lat);
      end
      checks++;
      if (bcnt !== 33) begin
        errors++;
        $display("FAIL %s[%0d] busy cycles: got %0d expected 33", name, i, bcnt);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] done width: done still %b after pulse", name, i, da);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    MulDivOp = 3'd0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b Result=%h expected 0 0 00000000",
               busy, done, Result);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops[4]  = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as[4]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[4]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps[4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    run_table("mul", ops, as, bs, exps);
    // Result must hold between done pulses
    repeat (5) @(negedge clk);
    checks++;
    if (Result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL result_hold: got %h expected ffffffff", Result);
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops[4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as[4]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs[4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    run_table("div", ops, as, bs, exps);
  endtask

  task automatic test_div_corner;
    logic [2:0]  ops[4]  = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as[4]   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs[4]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    run_table("divcorner", ops, as, bs, exps);
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int          lat, bcnt, ndone;
    logic        da;
    run_op(3'b101, 32'd100, 32'd7, res, lat, bcnt, da);
    checks++;
    if (res !== 32'd14) begin
      errors++;
      $display("FAIL flush_pre: got %h expected 0000000e", res);
    end
    @(negedge clk);
    MulDivOp = 3'b000; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_before: got %b expected 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_after: got %b expected 0", busy);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL flush_no_done: got %0d done pulses expected 0", ndone);
    end
    checks++;
    if (Result !== 32'd14) begin
      errors++;
      $display("FAIL flush_result_kept: got %h expected 0000000e", Result);
    end
    // flush and start together: flush wins
    MulDivOp = 3'b000; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    ndone = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_busy: got %b expected 0", busy);
    end
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL flush_start_no_done: got %0d done pulses expected 0", ndone);
    end
    run_op(3'b000, 32'd3, 32'd5, res, lat, bcnt, da);
    checks++;
    if (res !== 32'd15 || lat !== 34) begin
      errors++;
      $display("FAIL flush_recover: got %h lat %0d expected 0000000f lat 34", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, cap;
    int          lat, bcnt, ndone;
    logic        da;
    @(negedge clk);
    MulDivOp = 3'b101; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    MulDivOp = 3'b000; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        ndone++;
        cap = Result;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start_count: got %0d done pulses expected 1", ndone);
    end
    checks++;
    if (cap !== 32'd14) begin
      errors++;
      $display("FAIL ignore_start_result: got %h expected 0000000e", cap);
    end
    run_op(3'b111, 32'd100, 32'd7, res, lat, bcnt, da);
    checks++;
    if (res !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 00000002", res);
    end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bcnt, da);
    checks++;
    if (res !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_second: got %h expected fffffffe", res);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int          lat, bcnt, ndone;
    logic        da;
    @(negedge clk);
    MulDivOp = 3'b000; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b Result=%h expected 0 0 00000000",
               busy, done, Result);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", ndone);
    end
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, bcnt, da);
    checks++;
    if (res !== 32'hFFFFFFEB || lat !== 34) begin
      errors++;
      $display("FAIL reset_recover: got %h lat %0d expected ffffffeb lat 34", res, lat);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_corner;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, shall set the operand and result width; only 32 is required to be supported.
REQ-002 clk  input  1  the single clock; all state shall change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort from the pipeline hazard unit.
REQ-006 MulDivOp  input  3  operation code (RV32M funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcA  input  XLEN  first operand (multiplicand or dividend).
REQ-008 SrcB  input  XLEN  second operand (multiplier or divisor).
REQ-009 busy  output  1  high while an operation is in flight; the pipeline uses it to stall.
REQ-010 done  output  1  one-cycle pulse marking Result valid.
REQ-011 Result  output  XLEN  registered result of the last completed operation.

Function
REQ-012 FSM states shall be IDLE, CALC, FIX and DONE.
REQ-013 Transitions: IDLE->CALC on start; CALC->FIX after exactly 32 iterations; FIX->DONE; DONE->IDLE.
REQ-014 On start in IDLE, SrcA, SrcB and MulDivOp shall be latched, and later changes to these inputs shall not affect the result.
REQ-015 Latency shall be fixed for all ops and operands: done high exactly 34 cycles after the cycle in which start was sampled.
REQ-016 busy shall be high in CALC and FIX and low in IDLE and DONE.
REQ-017 done shall be high only in DONE, for exactly one cycle.
REQ-018 start while not in IDLE shall be ignored, with no queueing.
REQ-019 Multiply shall be iterative shift-add on operand magnitudes, producing a 64-bit product.
REQ-020 Multiply sign handling: MUL/MULH treat both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; MULHU treats both as unsigned.
REQ-021 MUL shall return product[31:0]; MULH, MULHSU and MULHU shall return product[63:32].
REQ-022 Divide shall be iterative restoring division on magnitudes; DIV/REM are signed, DIVU/REMU unsigned.
REQ-023 In signed division the quotient sign shall be sign(A) XOR sign(B), and the remainder sign shall equal the dividend's sign.
REQ-024 Sign correction (two's-complement negation) shall occur in FIX, and Result shall be loaded on the FIX->DONE edge.
REQ-025 Divide by zero: DIV/DIVU shall return 0xFFFFFFFF and REM/REMU shall return SrcA, with latency unchanged.
REQ-026 Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV shall return 0x80000000 and REM shall return 0, with latency unchanged.
REQ-027 Result shall hold its value between done pulses.
REQ-028 flush in any state shall force IDLE on the next edge: busy low, no done, Result unchanged.
REQ-029 flush and start asserted in the same cycle: flush shall win and no operation starts.
REQ-030 The iteration counter shall be 5 bits, cleared on entering CALC; CALC shall exit when the counter equals 31.

Reset
REQ-031 reset shall force IDLE, busy=0, done=0, Result=0, counter=0 and clear all internal accumulators, from any state including mid-CALC.
REQ-032 reset shall take priority over flush and start.

Structure
REQ-033 A shared package muldiv_pkg shall hold the MulDivOp encodings, the FSM state enum and the ITERATIONS=32 constant.
REQ-034 The block shall be a single module with no sub-module: the multiply and divide datapaths share the 64-bit accumulator and counter.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD -> Result 0xFFFFFFEB; done exactly 34 cycles after start; busy high for 33 cycles.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-038 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all at 34-cycle latency.
REQ-039 flush 10 cycles after start -> busy low next cycle, no done pulse, Result keeps prior value; a new start then completes normally.
REQ-040 Second start pulse 5 cycles into an operation -> ignored: exactly one done. reset mid-CALC -> all outputs zero on the next cycle.
